runner_ctrl: RTL and testbench

Player-side consumer of the surface generator's Floor/Ceiling shift-register outputs. Tracks which surface the runner stands on, performs gravity flips on a button press, detects a fall when the column under the runner has no surface, and keeps the run score. Sits between the surface generator and the display/score logic in the SegmentRunner top level.

---
 rtl/runner_pkg.sv | 16 +
 rtl/runner_ctrl_sat_counter.sv | 20 ++
 rtl/runner_ctrl.sv | 148 ++++++++++++++
 tb/tb_runner_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// Shared types and constants for the runner controller and its score counter.
package runner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FLIP = 2'd2,
    DEAD = 2'd3
  } runner_state_t;

  localparam int unsigned SURF_W = 6;

  localparam logic POS_FLOOR = 1'b0;
  localparam logic POS_CEIL  = 1'b1;

endpackage

// File: rtl/runner_ctrl_sat_counter.sv
// Score counter: synchronous clear and enable, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Clr,
  input  logic         En,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      Count <= '0;
    end else if (En && (Count != '1)) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/runner_ctrl.sv
// Runner controller: tracks floor/ceiling stance, gravity flips, falls and run score.
// Define RUNNER_HISCORE_EN to build the best-score register; otherwise HiScore is tied to 0.
module runner_ctrl
  import runner_pkg::*;
#(
  parameter int unsigned PLAYER_COL = 0,
  parameter int unsigned AIR_TICKS  = 2,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               MoveTick,
  input  logic [SURF_W-1:0]  Floor,
  input  logic [SURF_W-1:0]  Ceiling,
  input  logic               Start,
  input  logic               FlipBtn,
  output logic               PlayerPos,
  output logic               Airborne,
  output logic               Alive,
  output logic               GameOver,
  output logic [SCORE_W-1:0] Score,
  output logic [SCORE_W-1:0] HiScore
);

  localparam int unsigned AIR_W = 4;
  localparam logic [2:0]  COL   = 3'(PLAYER_COL);

  runner_state_t    state, stateNext;
  logic             chkTick;
  logic             flipPrev;
  logic             flipReq;
  logic [AIR_W-1:0] airCnt, airCntNext, airInc;
  logic             lastAir;
  logic             posNext;
  logic             scoreClr, scoreInc;
  logic             underBit, landBit;
  logic             enterDead;
  logic             unusedBits;

  assign flipReq   = FlipBtn & ~flipPrev;
  assign underBit  = (PlayerPos == POS_CEIL) ? Ceiling[COL] : Floor[COL];
  assign landBit   = (PlayerPos == POS_CEIL) ? Floor[COL] : Ceiling[COL];
  assign airInc    = airCnt + AIR_W'(1);
  assign lastAir   = (airInc == AIR_W'(AIR_TICKS));
  assign enterDead = (stateNext == DEAD) && (state != DEAD);
  assign unusedBits = ^{Floor, Ceiling};

  // Check strobe trails MoveTick by one Clk so the shifted surface is sampled
  always_ff @(posedge Clk) begin
    if (Rst) begin
      chkTick  <= 1'b0;
      flipPrev <= 1'b0;
    end else begin
      chkTick  <= MoveTick;
      flipPrev <= FlipBtn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      airCnt    <= '0;
      PlayerPos <= POS_FLOOR;
      Airborne  <= 1'b0;
      Alive     <= 1'b0;
      GameOver  <= 1'b0;
    end else begin
      state     <= stateNext;
      airCnt    <= airCntNext;
      PlayerPos <= posNext;
      Airborne  <= (stateNext == FLIP);
      Alive     <= (stateNext == RUN) || (stateNext == FLIP);
      GameOver  <= enterDead;
    end
  end

  // Check before flip in RUN; landing toggles stance and re-checks the new surface
  always_comb begin
    stateNext  = state;
    airCntNext = airCnt;
    posNext    = PlayerPos;
    scoreClr   = 1'b0;
    scoreInc   = 1'b0;
    case (state)
      IDLE, DEAD: begin
        if (Start) begin
          stateNext  = RUN;
          posNext    = POS_FLOOR;
          airCntNext = '0;
          scoreClr   = 1'b1;
        end
      end
      RUN: begin
        if (chkTick && !underBit) begin
          stateNext = DEAD;
        end else begin
          scoreInc = chkTick;
          if (flipReq) begin
            stateNext  = FLIP;
            airCntNext = '0;
          end
        end
      end
      FLIP: begin
        if (chkTick) begin
          if (lastAir) begin
            posNext    = ~PlayerPos;
            airCntNext = '0;
            if (landBit) begin
              stateNext = RUN;
              scoreInc  = 1'b1;
            end else begin
              stateNext = DEAD;
            end
          end else begin
            airCntNext = airInc;
            scoreInc   = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  sat_counter #(
    .W(SCORE_W)
  ) uScore (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (scoreClr),
    .En   (scoreInc),
    .Count(Score)
  );

`ifdef RUNNER_HISCORE_EN
  // Score is already final on the death edge, so it can be compared directly
  always_ff @(posedge Clk) begin
    if (Rst) begin
      HiScore <= '0;
    end else if (enterDead && (Score > HiScore)) begin
      HiScore <= Score;
    end
  end
`else
  assign HiScore = '0;
`endif

endmodule

// File: tb/tb_runner_ctrl.sv
// Bench for runner_ctrl: directed scenarios plus random play against a behavioural model.
module tb_runner_ctrl;

  localparam int unsigned SW   = 4;
  localparam int unsigned AT   = 2;
  localparam int          MAXS = (1 << SW) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLIP = 2, M_DEAD = 3;

  logic          Clk = 1'b0;
  logic          Rst, MoveTick, Start, FlipBtn;
  logic [5:0]    Floor, Ceiling;
  logic          PlayerPos, Airborne, Alive, GameOver;
  logic [SW-1:0] Score, HiScore;

  int nVec = 0;
  int nErr = 0;

  int mMode, mPos, mScore, mHi, mAir;
  bit mOver, mPend, mPrevBtn;

  runner_ctrl #(.PLAYER_COL(0), .AIR_TICKS(AT), .SCORE_W(SW)) dut (
    .Clk(Clk), .Rst(Rst), .MoveTick(MoveTick), .Floor(Floor), .Ceiling(Ceiling),
    .Start(Start), .FlipBtn(FlipBtn), .PlayerPos(PlayerPos), .Airborne(Airborne),
    .Alive(Alive), .GameOver(GameOver), .Score(Score), .HiScore(HiScore)
  );

  always #5 Clk = ~Clk;

  function automatic bit surf(input int pos);
    return (pos != 0) ? Ceiling[0] : Floor[0];
  endfunction

  task automatic die();
    if (mScore > mHi) mHi = mScore;
    mMode = M_DEAD;
    mOver = 1'b1;
  endtask

  task automatic bump();
    if (mScore < MAXS) mScore = mScore + 1;
  endtask

  // One Clk of game rules, applied to the inputs present before the edge
  task automatic modelEdge();
    bit chk;
    bit req;
    chk   = mPend;
    req   = FlipBtn && !mPrevBtn;
    mOver = 1'b0;
    if (Rst) begin
      mMode = M_IDLE; mPos = 0; mScore = 0; mHi = 0; mAir = 0;
      mPend = 1'b0; mPrevBtn = 1'b0;
      return;
    end
    if ((mMode == M_IDLE || mMode == M_DEAD) && Start) begin
      mMode = M_RUN; mPos = 0; mScore = 0; mAir = 0;
    end else if (mMode == M_RUN) begin
      if (chk) begin
        if (!surf(mPos)) die();
        else bump();
      end
      if (mMode == M_RUN && req) begin
        mMode = M_FLIP; mAir = 0;
      end
    end else if (mMode == M_FLIP && chk) begin
      mAir = mAir + 1;
      if (mAir == AT) begin
        mPos = 1 - mPos;
        if (surf(mPos)) begin
          mMode = M_RUN; bump();
        end else begin
          die();
        end
      end else begin
        bump();
      end
    end
    mPend    = MoveTick;
    mPrevBtn = FlipBtn;
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input int exp);
    nVec++;
    assert (obs === 16'(exp)) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int expHi;
`ifdef RUNNER_HISCORE_EN
    expHi = mHi;
`else
    expHi = 0;
`endif
    cmp("Alive",     16'(Alive),     int'(mMode == M_RUN || mMode == M_FLIP));
    cmp("Airborne",  16'(Airborne),  int'(mMode == M_FLIP));
    cmp("GameOver",  16'(GameOver),  int'(mOver));
    cmp("PlayerPos", 16'(PlayerPos), mPos);
    cmp("Score",     16'(Score),     mScore);
    cmp("HiScore",   16'(HiScore),   expHi);
  endtask

  task automatic step(input bit mt, input bit st, input bit r);
    MoveTick = mt;
    Start    = st;
    Rst      = r;
    @(posedge Clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  // MoveTick edge, surface lands, then the check edge and one spare Clk
  task automatic tick(input logic [5:0] nf, input logic [5:0] nc);
    step(1'b1, 1'b0, 1'b0);
    Floor   = nf;
    Ceiling = nc;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit mt, st, r, lastMt;
    Rst = 1'b1; MoveTick = 1'b0; Start = 1'b0; FlipBtn = 1'b0;
    Floor = 6'h3F; Ceiling = 6'h3F;
    mMode = M_IDLE; mPos = 0; mScore = 0; mHi = 0; mAir = 0;
    mOver = 1'b0; mPend = 1'b0; mPrevBtn = 1'b0;

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    cmp("rstAlive", 16'(Alive), 0);
    step(1'b0, 1'b0, 1'b0);

    // Basic run on solid floor
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(6'h3F, 6'h3F);
    cmp("basicScore", 16'(Score), 5);
    cmp("basicAlive", 16'(Alive), 1);

    // Floor gap: DEAD and a single GameOver pulse, score frozen
    tick(6'h3E, 6'h3F);
    cmp("gapScore", 16'(Score), 5);
    step(1'b0, 1'b0, 1'b0);

    // Flip to the ceiling
    Floor = 6'h3F;
    step(1'b0, 1'b1, 1'b0);
    FlipBtn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    cmp("flipAir", 16'(Airborne), 1);
    FlipBtn = 1'b0;
    tick(6'h3F, 6'h3F);
    tick(6'h3F, 6'h3F);
    cmp("flipPos", 16'(PlayerPos), 1);
    cmp("flipScore", 16'(Score), 2);

    // Flip back down into a floor gap at landing
    FlipBtn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    FlipBtn = 1'b0;
    tick(6'h3F, 6'h3F);
    tick(6'h3E, 6'h3F);
    cmp("landGapScore", 16'(Score), 3);

    // Gap check and flip rise on the same Clk
    Floor = 6'h3F;
    step(1'b0, 1'b1, 1'b0);
    tick(6'h3F, 6'h3F);
    step(1'b1, 1'b0, 1'b0);
    Floor   = 6'h3E;
    FlipBtn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    cmp("sameAirborne", 16'(Airborne), 0);
    FlipBtn = 1'b0;
    Floor = 6'h3F;
    step(1'b0, 1'b0, 1'b0);

    // Held button yields a single flip; long run saturates the score
    step(1'b0, 1'b1, 1'b0);
    FlipBtn = 1'b1;
    for (int i = 0; i < 20; i++) tick(6'h3F, 6'h3F);
    cmp("satScore", 16'(Score), MAXS);
    FlipBtn = 1'b0;
    tick(6'h3E, 6'h3E);
    step(1'b0, 1'b1, 1'b0);
    cmp("restartScore", 16'(Score), 0);
`ifdef RUNNER_HISCORE_EN
    cmp("hiScore", 16'(HiScore), MAXS);
`else
    cmp("hiScore", 16'(HiScore), 0);
`endif

    // Reset in the middle of a flip
    Floor = 6'h3F; Ceiling = 6'h3F;
    FlipBtn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    cmp("rstFlipAir",   16'(Airborne), 0);
    cmp("rstFlipScore", 16'(Score), 0);
    cmp("rstFlipHi",    16'(HiScore), 0);
    FlipBtn = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Random play
    lastMt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (lastMt) begin
        Floor      = 6'($urandom);
        Ceiling    = 6'($urandom);
        Floor[0]   = ($urandom_range(0, 7) != 0);
        Ceiling[0] = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 5) == 0) FlipBtn = ~FlipBtn;
      mt = !lastMt && ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(mt, st, r);
      lastMt = mt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
